// File: rtl/mnist_pkg.sv
// Shared constants, FSM state type and weight-bus helper for the MNIST classifier core.
package mnist_pkg;
  localparam int N_CLASSES = 10;
  localparam int N_PIXELS  = 784;
  localparam int PIX_W     = 8;
  localparam int W_W       = 8;
  localparam int B_W       = 16;
  localparam int ACC_W     = 32;
  localparam int PROD_W    = PIX_W + W_W + 1;
  localparam int BL_W      = 12;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ARGMAX,
    S_DONE
  } state_t;

  function automatic logic signed [W_W-1:0] weight_slice(
    input logic [N_CLASSES*W_W-1:0] w,
    input int unsigned              k
  );
    return w[k*W_W +: W_W];
  endfunction
endpackage

// File: rtl/mnist_mac_lane.sv
// One class accumulator: bias load, pixel*weight accumulate, synchronous clear.
module mnist_mac_lane
  import mnist_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic signed [B_W-1:0]   i_bias,
  input  logic                    i_acc_en,
  input  logic        [PIX_W-1:0] i_pix,
  input  logic signed [W_W-1:0]   i_wt,
  input  logic                    i_clr,
  output logic signed [ACC_W-1:0] o_acc
);
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [PROD_W-1:0] w_pix_ext;
  logic signed [PROD_W-1:0] w_wt_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  w_next;

  // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
  assign w_pix_ext = {{(PROD_W-PIX_W){1'b0}}, i_pix};
  assign w_wt_ext  = {{(PROD_W-W_W){i_wt[W_W-1]}}, i_wt};
  assign w_prod    = w_pix_ext * w_wt_ext;

  // A bias load in the same cycle as the first pixel seeds the sum before the add.
  assign w_base = i_load ? {{(ACC_W-B_W){i_bias[B_W-1]}}, i_bias} : r_acc;
  assign w_next = i_acc_en ? w_base + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod} : w_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_load || i_acc_en) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/mnist_classifier_core.sv
// MNIST scoring core: per-class MAC over a pixel stream, then a serial argmax (one class/cycle).
module mnist_classifier_core
  import mnist_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BL_W-1:0]            bias_load,
  input  logic [B_W-1:0]             bias_data,
  input  logic                       valid_pixel,
  input  logic [PIX_W-1:0]           pixel_data,
  input  logic [N_CLASSES*W_W-1:0]   weight_data,
  output logic                       busy,
  output logic                       result_valid,
  output logic [IDX_W-1:0]           result_digit,
  output logic [ACC_W-1:0]           result_score,
  output logic                       protocol_err
);
  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_pix_cnt;
  logic [IDX_W-1:0]        r_idx, r_best_idx, w_win_idx;
  logic signed [ACC_W-1:0] r_best, w_cur, w_win;
  logic signed [ACC_W-1:0] w_acc [N_CLASSES];
  logic [N_CLASSES-1:0]    w_load;
  logic                    w_acc_en, w_clr, w_err_set, w_last_idx, w_strobe;
  logic                    r_result_valid, r_perr;
  logic [IDX_W-1:0]        r_result_digit;
  logic [ACC_W-1:0]        r_result_score;
  logic                    w_unused_bl;

  assign w_unused_bl = ^bias_load[BL_W-1:N_CLASSES];
  assign w_strobe    = |bias_load[N_CLASSES-1:0];
  assign w_last_idx  = (r_idx == IDX_W'(N_CLASSES-1));

  for (genvar g = 0; g < N_CLASSES; g++) begin : g_lane
    mnist_mac_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load[g]),
      .i_bias   ($signed(bias_data)),
      .i_acc_en (w_acc_en),
      .i_pix    (pixel_data),
      .i_wt     (weight_slice(weight_data, g)),
      .i_clr    (w_clr),
      .o_acc    (w_acc[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = '0;
    w_acc_en    = 1'b0;
    w_clr       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load   = bias_load[N_CLASSES-1:0];
        w_acc_en = valid_pixel;
        if (valid_pixel) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        w_acc_en  = valid_pixel;
        w_err_set = w_strobe;
        if (valid_pixel && r_pix_cnt == CNT_W'(N_PIXELS-1)) w_state_nxt = S_ARGMAX;
      end
      S_ARGMAX: begin
        w_err_set = valid_pixel || w_strobe;
        if (w_last_idx) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_err_set   = valid_pixel || w_strobe;
        w_clr       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cur = '0;
    for (int k = 0; k < N_CLASSES; k++) begin
      if (r_idx == IDX_W'(k)) w_cur = w_acc[k];
    end
  end

  // Index 0 seeds the running best; strict compare keeps the lowest index on ties.
  always_comb begin
    if (r_idx == '0 || w_cur > r_best) begin
      w_win     = w_cur;
      w_win_idx = r_idx;
    end else begin
      w_win     = r_best;
      w_win_idx = r_best_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt      <= '0;
      r_idx          <= '0;
      r_best         <= '0;
      r_best_idx     <= '0;
      r_result_valid <= 1'b0;
      r_result_digit <= '0;
      r_result_score <= '0;
      r_perr         <= 1'b0;
    end else begin
      if (w_clr)         r_pix_cnt <= '0;
      else if (w_acc_en) r_pix_cnt <= r_pix_cnt + 1'b1;
      r_idx <= (r_state == S_ARGMAX) ? r_idx + 1'b1 : '0;
      if (r_state == S_ARGMAX) begin
        r_best     <= w_win;
        r_best_idx <= w_win_idx;
      end
      r_result_valid <= (r_state == S_ARGMAX) && w_last_idx;
      if ((r_state == S_ARGMAX) && w_last_idx) begin
        r_result_digit <= w_win_idx;
        r_result_score <= w_win;
      end
      r_perr <= r_perr | w_err_set;
    end
  end

  assign busy         = (r_state == S_ACCUM) || (r_state == S_ARGMAX);
  assign result_valid = r_result_valid;
  assign result_digit = r_result_digit;
  assign result_score = r_result_score;
  assign protocol_err = r_perr;
endmodule

// File: tb/tb_mnist_classifier_core.sv
// Scoreboard bench: driver pushes reference-model results, monitor pops on result_valid.
module tb_mnist_classifier_core;
  import mnist_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [BL_W-1:0]          bias_load = '0;
  logic [B_W-1:0]           bias_data = '0;
  logic                     valid_pixel = 1'b0;
  logic [PIX_W-1:0]         pixel_data = '0;
  logic [N_CLASSES*W_W-1:0] weight_data = '0;
  logic                     busy, result_valid, protocol_err;
  logic [IDX_W-1:0]         result_digit;
  logic [ACC_W-1:0]         result_score;

  mnist_classifier_core dut (
    .clk(clk), .rst(rst), .bias_load(bias_load), .bias_data(bias_data),
    .valid_pixel(valid_pixel), .pixel_data(pixel_data), .weight_data(weight_data),
    .busy(busy), .result_valid(result_valid), .result_digit(result_digit),
    .result_score(result_score), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     digit;
    longint score;
    int     e0;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_n = 0;
  logic prev_rv = 1'b0;

  int bias_v [N_CLASSES];
  int pix_v  [N_PIXELS];
  int wt_v   [N_PIXELS][N_CLASSES];

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Plain arithmetic reference: score = bias + sum(pixel*weight), first maximum wins.
  task automatic model(output int dg, output longint sc);
    longint acc [N_CLASSES];
    for (int k = 0; k < N_CLASSES; k++) begin
      acc[k] = bias_v[k];
      for (int p = 0; p < N_PIXELS; p++) acc[k] += longint'(pix_v[p]) * wt_v[p][k];
    end
    dg = 0;
    sc = acc[0];
    for (int k = 1; k < N_CLASSES; k++) begin
      if (acc[k] > sc) begin
        sc = acc[k];
        dg = k;
      end
    end
  endtask

  task automatic set_uniform(input int b, input int px, input int w);
    for (int k = 0; k < N_CLASSES; k++) bias_v[k] = b;
    for (int p = 0; p < N_PIXELS; p++) begin
      pix_v[p] = px;
      for (int k = 0; k < N_CLASSES; k++) wt_v[p][k] = w;
    end
  endtask

  task automatic rand_image();
    for (int k = 0; k < N_CLASSES; k++) bias_v[k] = int'($urandom_range(0, 65535)) - 32768;
    for (int p = 0; p < N_PIXELS; p++) begin
      pix_v[p] = int'($urandom_range(0, 255));
      for (int k = 0; k < N_CLASSES; k++) wt_v[p][k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    #1;
    if (result_valid) begin
      chk("result_valid_single_cycle", prev_rv, 0);
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_digit", result_digit, e.digit);
        chk("result_score", $signed(result_score), e.score);
        chk("result_latency", edge_n - e.e0, 10);
      end
    end
    prev_rv = result_valid;
  end

  // co_cls >= 0: that class's real bias arrives with pixel 0 (a junk value is loaded first).
  // inj_err: strobe bias bit 2 mid-image and send a stray pixel during argmax.
  // abort_at >= 0: assert reset instead of sending that pixel.
  task automatic drive_image(input int gap_pct, input int co_cls, input bit inj_err, input int abort_at);
    int     dg;
    longint sc;
    for (int k = 0; k < N_CLASSES; k++) begin
      @(negedge clk);
      bias_load = BL_W'(1 << k);
      if ($urandom_range(0, 1) == 1) bias_load[BL_W-1:N_CLASSES] = 2'($urandom);
      bias_data = (k == co_cls) ? B_W'($urandom) : B_W'(bias_v[k]);
    end
    @(negedge clk);
    bias_load = '0;
    for (int p = 0; p < N_PIXELS; p++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        @(negedge clk);
        valid_pixel = 1'b0;
        bias_load   = '0;
      end
      if (inj_err && p == 100) begin
        @(negedge clk);
        valid_pixel = 1'b0;
        bias_load   = BL_W'(4);
        bias_data   = B_W'($urandom);
      end
      if (p == abort_at) begin
        @(negedge clk);
        valid_pixel = 1'b0;
        bias_load   = '0;
        rst         = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result_valid", result_valid, 0);
        chk("abort_result_digit", result_digit, 0);
        chk("abort_result_score", result_score, 0);
        chk("abort_protocol_err", protocol_err, 0);
        return;
      end
      @(negedge clk);
      valid_pixel = 1'b1;
      pixel_data  = PIX_W'(pix_v[p]);
      for (int k = 0; k < N_CLASSES; k++) weight_data[k*W_W +: W_W] = W_W'(wt_v[p][k]);
      if (p == 0 && co_cls >= 0) begin
        bias_load = BL_W'(1 << co_cls);
        bias_data = B_W'(bias_v[co_cls]);
      end else begin
        bias_load = '0;
      end
      if (p == N_PIXELS / 2) begin
        @(posedge clk);
        #1;
        chk("busy_in_accum", busy, 1);
      end
    end
    @(posedge clk);
    #1;
    model(dg, sc);
    sb.push_back('{dg, sc, edge_n});
    @(negedge clk);
    valid_pixel = inj_err;
    bias_load   = '0;
    @(negedge clk);
    valid_pixel = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 40) begin
      @(posedge clk);
      i++;
    end
    chk("result_timeout_pending", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_result_valid", result_valid, 0);
    chk("reset_result_digit", result_digit, 0);
    chk("reset_result_score", result_score, 0);
    chk("reset_protocol_err", protocol_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    set_uniform(0, 1, 0);
    for (int p = 0; p < N_PIXELS; p++) wt_v[p][3] = 1;
    drive_image(0, -1, 1'b0, -1);
    wait_done();

    set_uniform(0, 1, 0);
    for (int k = 0; k < N_CLASSES; k++) bias_v[k] = k * 10;
    for (int p = 0; p < N_PIXELS; p++) pix_v[p] = int'($urandom_range(0, 255));
    drive_image(0, -1, 1'b0, -1);
    wait_done();

    set_uniform(5, 1, 2);
    drive_image(0, -1, 1'b0, -1);
    wait_done();

    set_uniform(-5, 0, 0);
    bias_v[6] = -4;
    for (int p = 0; p < N_PIXELS; p++) pix_v[p] = int'($urandom_range(0, 255));
    drive_image(10, -1, 1'b0, -1);
    wait_done();

    set_uniform(0, 255, 127);
    for (int p = 0; p < N_PIXELS; p++) wt_v[p][0] = -128;
    drive_image(0, -1, 1'b0, -1);
    wait_done();
    chk("protocol_err_clean", protocol_err, 0);

    for (int t = 0; t < 4; t++) begin
      rand_image();
      drive_image((t % 2) * 20, (t >= 2) ? int'($urandom_range(0, N_CLASSES-1)) : -1, 1'b0, -1);
      wait_done();
    end

    rand_image();
    drive_image(10, -1, 1'b0, 400);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rand_image();
    drive_image(5, -1, 1'b0, -1);
    wait_done();
    chk("protocol_err_after_abort", protocol_err, 0);

    rand_image();
    for (int p = 0; p < N_PIXELS; p++) wt_v[p][2] = 127;
    bias_v[2] = 0;
    drive_image(0, -1, 1'b1, -1);
    wait_done();
    chk("protocol_err_sticky", protocol_err, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("protocol_err_reset", protocol_err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
